fetch_stall_ctrl: RTL and testbench
===================================

FETCH_STALL_CTRL -- requirements
Module: fetch_stall_ctrl

Interface
REQ-001 Parameter BR_STALL, default 3, bubble cycles after a fetched beq/bne/j; legal range 1..15.
REQ-002 Parameter MUL_STALL, default 34, bubble cycles after a fetched mul; legal range 1..63.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 instr_i  input  32  raw word from instruction memory at current PC.
REQ-006 pc_en_o  output  1  enable for PC register; 1 = load pc_next this edge.
REQ-007 bubble_o  output  1  1 = IF/ID must capture a nop instead of instr_i.
REQ-008 instr_o  output  32  instr_i when bubble_o=0, else 32'h0000_0000; feeds IF/ID inst input.
REQ-009 busy_o  output  1  1 while FSM is not IDLE.
REQ-010 stall_cnt_o  output  6  remaining bubble cycles, 0 in IDLE.
REQ-011 stall_total_o  output  32  saturating count of cycles with bubble_o=1.

Function
REQ-012 Hazard classes: BR = opcode 6'd4 (beq) or 6'd5 (bne); JMP = opcode 6'd2; MUL = opcode 0 with funct 6'd25; NONE = anything else, including 32'h0.
REQ-013 FSM states: IDLE, STALL_BR, STALL_MUL; STALL_BR also serves JMP.
REQ-014 IDLE with class NONE: pc_en_o=1, bubble_o=0, instr_o=instr_i, no state change.
REQ-015 IDLE with BR or JMP: pc_en_o=0, bubble_o=0, instr_o=instr_i (hazard instruction enters IF/ID once); next state STALL_BR, counter loaded with BR_STALL.
REQ-016 IDLE with MUL: pc_en_o=0, bubble_o=0, instr_o=instr_i; next state STALL_MUL, counter loaded with MUL_STALL.
REQ-017 In either STALL state: bubble_o=1, instr_o=0, instr_i ignored (held PC re-presents the same hazard word; it shall not retrigger).
REQ-018 In either STALL state: pc_en_o=1 only when counter==1, else 0; counter decrements by 1 every cycle.
REQ-019 When counter==1 in a STALL state, next state IDLE and counter becomes 0; the first instruction fetched from the new PC is classified in IDLE on the following cycle.
REQ-020 A hazard word presented in the cycle after returning to IDLE is handled per REQ-015/016 with no extra gap (back-to-back hazards).
REQ-021 Total latency per hazard: 1 detect cycle + N bubble cycles; PC is held for N cycles and loads on the last bubble cycle.
REQ-022 stall_total_o increments by 1 on each clk edge where bubble_o=1; holds at 32'hFFFF_FFFF once reached.
REQ-023 busy_o = (state != IDLE); stall_cnt_o = counter value, zero-extended to 6 bits.

Reset
REQ-024 While rst=1: state IDLE, counter 0, stall_total_o 0, and outputs forced to pc_en_o=1, bubble_o=0, instr_o=instr_i, busy_o=0, with no hazard classification.
REQ-025 rst asserted mid-stall aborts the stall at the next edge; no residual bubble after rst deasserts.
REQ-026 rst takes priority over every other transition in the same cycle.

Structure
REQ-027 Shared pipeline package holds: opcode constants (BEQ=4, BNE=5, J=2, RTYPE=0), funct MUL=25, the 2-bit hazard-class enum, and the FSM state enum.
REQ-028 One combinational sub-module, hazard_decode, maps instr_i to the hazard class; all sequential logic stays in fetch_stall_ctrl.
REQ-029 All state (FSM, counter, stall_total_o) held in flops updated only on rising edge of clk; no delay constructs.

Verification
REQ-030 Reset, then feed add ($0 opcode, funct 32) for 5 cycles -> pc_en_o=1, bubble_o=0 every cycle; stall_total_o=0.
REQ-031 beq word 32'h1022_0003 held on instr_i -> cycle0 pc_en_o=0,bubble_o=0; cycles1-3 bubble_o=1 with pc_en_o=0,0,1; cycle4 IDLE; stall_total_o=3.
REQ-032 mul word 32'h0022_1819 held -> 34 bubble cycles, pc_en_o=1 only on the 34th, stall_cnt_o counts 34 down to 1; stall_total_o=34.
REQ-033 j 32'h0800_0010 immediately followed by bne 32'h1443_FFFE -> two stall windows of 3 with exactly one non-bubble detect cycle between; stall_total_o=6.
REQ-034 Assert rst for 1 cycle during bubble 10 of a mul stall -> next cycle IDLE, busy_o=0, stall_total_o=0, fetched add passes with pc_en_o=1.
REQ-035 Preload stall_total_o to 32'hFFFF_FFFE via forced state, run a beq -> counter reads 32'hFFFF_FFFF and stays there.

Source files
------------

// File: rtl/fetch_stall_ctrl_pkg.sv
// Shared pipeline definitions for the fetch stall controller: opcodes,
// hazard classes and stall FSM states.
package fetch_stall_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE  = 6'd0;
  localparam logic [5:0] OP_J      = 6'd2;
  localparam logic [5:0] OP_BEQ    = 6'd4;
  localparam logic [5:0] OP_BNE    = 6'd5;
  localparam logic [5:0] FUNCT_MUL = 6'd25;

  typedef enum logic [1:0] {
    HZ_NONE = 2'd0,
    HZ_BR   = 2'd1,
    HZ_JMP  = 2'd2,
    HZ_MUL  = 2'd3
  } hazard_class_t;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_STALL_BR  = 2'd1,
    ST_STALL_MUL = 2'd2
  } stall_state_t;

endpackage

// File: rtl/fetch_stall_ctrl_hazard_decode.sv
// Combinational classifier: opcode/funct of the fetched word -> hazard class.
module hazard_decode
  import fetch_stall_ctrl_pkg::*;
(
  input  logic [5:0]    opcode,
  input  logic [5:0]    funct,
  output hazard_class_t hz_class
);

  // classify the fetched instruction
  always_comb begin
    hz_class = HZ_NONE;
    case (opcode)
      OP_BEQ, OP_BNE: hz_class = HZ_BR;
      OP_J:           hz_class = HZ_JMP;
      OP_RTYPE: begin
        if (funct == FUNCT_MUL) begin
          hz_class = HZ_MUL;
        end else begin
          hz_class = HZ_NONE;
        end
      end
      default:        hz_class = HZ_NONE;
    endcase
  end

endmodule

// File: rtl/fetch_stall_ctrl.sv
// Fetch-stage stall controller: holds the PC and injects nops into IF/ID
// for a fixed number of cycles after a branch, jump or multiply is fetched.
module fetch_stall_ctrl
  import fetch_stall_ctrl_pkg::*;
#(
  parameter int unsigned BR_STALL  = 3,
  parameter int unsigned MUL_STALL = 34
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr_i,
  output logic        pc_en_o,
  output logic        bubble_o,
  output logic [31:0] instr_o,
  output logic        busy_o,
  output logic [5:0]  stall_cnt_o,
  output logic [31:0] stall_total_o
);

  localparam logic [5:0] BR_CNT  = 6'(BR_STALL);
  localparam logic [5:0] MUL_CNT = 6'(MUL_STALL);

  hazard_class_t hz_class_s;
  stall_state_t  state_r;
  stall_state_t  state_nxt_s;
  logic [5:0]    cnt_r;
  logic [5:0]    cnt_nxt_s;
  logic [31:0]   total_r;
  logic          pc_en_s;
  logic          bubble_s;

  hazard_decode u_hazard_decode (
    .opcode   (instr_i[31:26]),
    .funct    (instr_i[5:0]),
    .hz_class (hz_class_s)
  );

  // next-state, counter and fetch-control decode; reset overrides everything
  always_comb begin
    pc_en_s     = 1'b1;
    bubble_s    = 1'b0;
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    if (rst) begin
      state_nxt_s = ST_IDLE;
      cnt_nxt_s   = 6'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          case (hz_class_s)
            HZ_BR, HZ_JMP: begin
              pc_en_s     = 1'b0;
              state_nxt_s = ST_STALL_BR;
              cnt_nxt_s   = BR_CNT;
            end
            HZ_MUL: begin
              pc_en_s     = 1'b0;
              state_nxt_s = ST_STALL_MUL;
              cnt_nxt_s   = MUL_CNT;
            end
            default: begin
              pc_en_s     = 1'b1;
            end
          endcase
        end
        ST_STALL_BR, ST_STALL_MUL: begin
          // the held PC keeps presenting the hazard word, so instr_i is ignored
          bubble_s = 1'b1;
          if (cnt_r == 6'd1) begin
            pc_en_s     = 1'b1;
            state_nxt_s = ST_IDLE;
            cnt_nxt_s   = 6'd0;
          end else begin
            pc_en_s     = 1'b0;
            cnt_nxt_s   = cnt_r - 6'd1;
          end
        end
        default: begin
          state_nxt_s = ST_IDLE;
          cnt_nxt_s   = 6'd0;
        end
      endcase
    end
  end

  // FSM and counter registers
  always_ff @(posedge clk) begin
    state_r <= state_nxt_s;
    cnt_r   <= cnt_nxt_s;
  end

  // saturating count of bubble cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      total_r <= 32'd0;
    end else if (bubble_s && (total_r != 32'hFFFF_FFFF)) begin
      total_r <= total_r + 32'd1;
    end else begin
      total_r <= total_r;
    end
  end

  assign pc_en_o       = pc_en_s;
  assign bubble_o      = bubble_s;
  assign instr_o       = bubble_s ? 32'h0000_0000 : instr_i;
  assign busy_o        = (!rst) && (state_r != ST_IDLE);
  assign stall_cnt_o   = rst ? 6'd0 : cnt_r;
  assign stall_total_o = rst ? 32'd0 : total_r;

endmodule

// File: tb/tb_fetch_stall_ctrl.sv
// Directed self-checking bench for fetch_stall_ctrl (default parameters).
module tb_fetch_stall_ctrl;

  localparam logic [31:0] W_ADD  = 32'h0022_1820;
  localparam logic [31:0] W_BEQ  = 32'h1022_0003;
  localparam logic [31:0] W_MUL  = 32'h0022_1819;
  localparam logic [31:0] W_J    = 32'h0800_0010;
  localparam logic [31:0] W_BNE  = 32'h1443_FFFE;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] instr_i = 32'h0;
  logic        pc_en_o;
  logic        bubble_o;
  logic [31:0] instr_o;
  logic        busy_o;
  logic [5:0]  stall_cnt_o;
  logic [31:0] stall_total_o;

  int total = 0;
  int bad   = 0;

  fetch_stall_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .instr_i       (instr_i),
    .pc_en_o       (pc_en_o),
    .bubble_o      (bubble_o),
    .instr_o       (instr_o),
    .busy_o        (busy_o),
    .stall_cnt_o   (stall_cnt_o),
    .stall_total_o (stall_total_o)
  );

  always #5 clk = ~clk;

  // present a word for one cycle; outputs are settled 1 time unit later
  task automatic cyc(input logic [31:0] w);
    @(negedge clk);
    instr_i = w;
    #1;
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst = 1'b1;
    instr_i = W_ADD;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst = 1'b1;
    instr_i = W_BEQ;
    #1;
    total++;
    if (pc_en_o !== 1'b1 || bubble_o !== 1'b0 || instr_o !== W_BEQ) begin
      bad++;
      $display("FAIL reset_outputs pc_en=%b bubble=%b instr=%h want 1 0 %h", pc_en_o, bubble_o, instr_o, W_BEQ);
    end
    @(negedge clk);
    #1;
    total++;
    if (busy_o !== 1'b0 || stall_cnt_o !== 6'd0 || stall_total_o !== 32'd0) begin
      bad++;
      $display("FAIL reset_state busy=%b cnt=%0d tot=%0d want 0 0 0", busy_o, stall_cnt_o, stall_total_o);
    end
    rst = 1'b0;
  endtask

  task automatic test_none;
    logic [31:0] words [6];
    words = '{W_ADD, 32'h0000_0000, 32'h0022_1818, 32'h0C00_0010, 32'h1843_0001, W_ADD};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      cyc(words[i]);
      total++;
      if (pc_en_o !== 1'b1 || bubble_o !== 1'b0 || busy_o !== 1'b0 || instr_o !== words[i]) begin
        bad++;
        $display("FAIL none_%0d pc_en=%b bubble=%b busy=%b instr=%h want 1 0 0 %h", i, pc_en_o, bubble_o, busy_o, instr_o, words[i]);
      end
    end
    total++;
    if (stall_total_o !== 32'd0) begin
      bad++;
      $display("FAIL none_total got=%0d want 0", stall_total_o);
    end
  endtask

  task automatic test_beq;
    logic exp_pc [4];
    exp_pc = '{1'b0, 1'b0, 1'b0, 1'b1};
    do_reset();
    cyc(W_BEQ);
    total++;
    if (pc_en_o !== 1'b0 || bubble_o !== 1'b0 || instr_o !== W_BEQ || busy_o !== 1'b0) begin
      bad++;
      $display("FAIL beq_detect pc_en=%b bubble=%b instr=%h busy=%b want 0 0 %h 0", pc_en_o, bubble_o, instr_o, busy_o, W_BEQ);
    end
    for (int i = 1; i <= 3; i++) begin
      cyc(W_BEQ);
      total++;
      if (bubble_o !== 1'b1 || pc_en_o !== exp_pc[i] || instr_o !== 32'h0 || busy_o !== 1'b1 ||
          stall_cnt_o !== 6'(4 - i)) begin
        bad++;
        $display("FAIL beq_bubble_%0d bubble=%b pc_en=%b instr=%h busy=%b cnt=%0d want 1 %b 0 1 %0d",
                 i, bubble_o, pc_en_o, instr_o, busy_o, stall_cnt_o, exp_pc[i], 4 - i);
      end
    end
    cyc(W_ADD);
    total++;
    if (busy_o !== 1'b0 || bubble_o !== 1'b0 || pc_en_o !== 1'b1 || stall_cnt_o !== 6'd0 || stall_total_o !== 32'd3) begin
      bad++;
      $display("FAIL beq_after busy=%b bubble=%b pc_en=%b cnt=%0d tot=%0d want 0 0 1 0 3",
               busy_o, bubble_o, pc_en_o, stall_cnt_o, stall_total_o);
    end
  endtask

  task automatic test_mul;
    do_reset();
    cyc(W_MUL);
    total++;
    if (pc_en_o !== 1'b0 || bubble_o !== 1'b0 || instr_o !== W_MUL) begin
      bad++;
      $display("FAIL mul_detect pc_en=%b bubble=%b instr=%h want 0 0 %h", pc_en_o, bubble_o, instr_o, W_MUL);
    end
    for (int i = 1; i <= 34; i++) begin
      cyc(W_MUL);
      total++;
      if (bubble_o !== 1'b1 || pc_en_o !== (i == 34) || stall_cnt_o !== 6'(35 - i)) begin
        bad++;
        $display("FAIL mul_bubble_%0d bubble=%b pc_en=%b cnt=%0d want 1 %b %0d",
                 i, bubble_o, pc_en_o, stall_cnt_o, (i == 34), 35 - i);
      end
    end
    cyc(W_ADD);
    total++;
    if (busy_o !== 1'b0 || pc_en_o !== 1'b1 || stall_total_o !== 32'd34) begin
      bad++;
      $display("FAIL mul_after busy=%b pc_en=%b tot=%0d want 0 1 34", busy_o, pc_en_o, stall_total_o);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] seq    [9];
    logic        exp_bub[9];
    logic        exp_pc [9];
    seq     = '{W_J, W_J, W_J, W_J, W_BNE, W_BNE, W_BNE, W_BNE, W_ADD};
    exp_bub = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    exp_pc  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    do_reset();
    for (int i = 0; i < 9; i++) begin
      cyc(seq[i]);
      total++;
      if (bubble_o !== exp_bub[i] || pc_en_o !== exp_pc[i]) begin
        bad++;
        $display("FAIL b2b_cycle_%0d bubble=%b pc_en=%b want %b %b", i, bubble_o, pc_en_o, exp_bub[i], exp_pc[i]);
      end
    end
    total++;
    if (stall_total_o !== 32'd6) begin
      bad++;
      $display("FAIL b2b_total got=%0d want 6", stall_total_o);
    end
  endtask

  task automatic test_rst_mid_stall;
    do_reset();
    cyc(W_MUL);
    for (int i = 1; i <= 9; i++) begin
      cyc(W_MUL);
    end
    @(negedge clk);
    rst = 1'b1;
    instr_i = W_MUL;
    #1;
    total++;
    if (pc_en_o !== 1'b1 || bubble_o !== 1'b0 || busy_o !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid_force pc_en=%b bubble=%b busy=%b want 1 0 0", pc_en_o, bubble_o, busy_o);
    end
    @(negedge clk);
    rst = 1'b0;
    instr_i = W_ADD;
    #1;
    total++;
    if (busy_o !== 1'b0 || bubble_o !== 1'b0 || pc_en_o !== 1'b1 || stall_total_o !== 32'd0 || instr_o !== W_ADD) begin
      bad++;
      $display("FAIL rst_mid_after busy=%b bubble=%b pc_en=%b tot=%0d instr=%h want 0 0 1 0 %h",
               busy_o, bubble_o, pc_en_o, stall_total_o, instr_o, W_ADD);
    end
  endtask

  task automatic test_saturate;
    do_reset();
    @(negedge clk);
    instr_i = W_ADD;
    force dut.total_r = 32'hFFFF_FFFE;
    #1;
    release dut.total_r;
    #1;
    total++;
    if (stall_total_o !== 32'hFFFF_FFFE) begin
      bad++;
      $display("FAIL sat_preload got=%h want fffffffe", stall_total_o);
    end
    cyc(W_BEQ);
    cyc(W_BEQ);
    cyc(W_BEQ);
    total++;
    if (stall_total_o !== 32'hFFFF_FFFF) begin
      bad++;
      $display("FAIL sat_reach got=%h want ffffffff", stall_total_o);
    end
    cyc(W_BEQ);
    cyc(W_ADD);
    total++;
    if (stall_total_o !== 32'hFFFF_FFFF) begin
      bad++;
      $display("FAIL sat_hold got=%h want ffffffff", stall_total_o);
    end
  endtask

  initial begin
    test_reset();
    test_none();
    test_beq();
    test_mul();
    test_back_to_back();
    test_rst_mid_stall();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
